// File: rtl/cg_pkg.sv
// Shared constants and helpers for the CG vector stream memory.
// Word-count rounding lives here so every user agrees on pass length.
package cg_pkg;

    localparam int ELEMENT_WIDTH = 32;
    localparam int NO_OF_UNITS   = 8;
    localparam int MEMORY_HEIGHT = 1000;
    localparam int ADDRESS_WIDTH = $clog2(MEMORY_HEIGHT) + 1;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_HOLD
    } rd_state_t;

    // ceil(total/units) in 32-bit arithmetic, saturated at the storage depth
    function automatic logic [31:0] words_of(
        input logic [31:0] total,
        input int          units,
        input int          height
    );
        logic [31:0] w;
        w = (total + 32'(units) - 32'd1) / 32'(units);
        if (w > 32'(height))
            w = 32'(height);
        return w;
    endfunction

endpackage

// File: rtl/cg_vector_stream_mem_ram.sv
// Simple dual-port word RAM: one synchronous write, one synchronous read.
// A same-address write and read in one cycle returns the old contents.
module vector_ram #(
    parameter int DEPTH = 1000,
    parameter int WIDTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [IW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [IW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Storage is never cleared; only the output register resets.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cg_vector_stream_mem.sv
// Memory endpoint for one CG vector: absorbs the ALU write-back stream
// and replays it as a valid/ready read stream with restart support.
module cg_vector_stream_mem
    import cg_pkg::*;
#(
    parameter int element_width = ELEMENT_WIDTH,
    parameter int no_of_units   = NO_OF_UNITS,
    parameter int memory_height = MEMORY_HEIGHT,
    parameter int address_width = $clog2(memory_height) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [31:0]                          total,
    input  logic                                 wr_we,
    input  logic [element_width*no_of_units-1:0] wr_data,
    input  logic                                 read_again,
    input  logic                                 rd_ready,
    output logic                                 rd_valid,
    output logic [element_width*no_of_units-1:0] rd_data,
    output logic [address_width-1:0]             rd_address,
    output logic [address_width-1:0]             wr_address,
    output logic                                 write_done,
    output logic                                 read_done
);

    localparam int IW = $clog2(memory_height);

    logic [address_width-1:0] w_words;
    logic [address_width-1:0] w_wr_len;
    logic                     w_wr_en;
    logic                     w_rd_en;

    logic [address_width-1:0] r_wr_address;
    logic [address_width-1:0] r_wr_words;
    logic                     r_write_done;

    rd_state_t                r_state;
    logic [address_width-1:0] r_rd_address;
    logic [address_width-1:0] r_rd_words;
    logic                     r_rd_valid;
    logic                     r_read_done;

    assign w_words = address_width'(words_of(total, no_of_units, memory_height));

    // At word 0 the pass length is taken live from total, later from the latch.
    assign w_wr_len = (r_wr_address == '0) ? w_words : r_wr_words;
    assign w_wr_en  = wr_we && (w_wr_len != '0);
    assign w_rd_en  = (r_state == RD_ISSUE) && !read_again;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_address <= '0;
            r_wr_words   <= '0;
            r_write_done <= 1'b0;
        end else begin
            r_write_done <= 1'b0;
            if (wr_we) begin
                if (r_wr_address == '0)
                    r_wr_words <= w_words;
                if (w_wr_len == '0) begin
                    r_write_done <= 1'b1;
                end else if (r_wr_address == w_wr_len - 1'b1) begin
                    r_wr_address <= '0;
                    r_write_done <= 1'b1;
                end else begin
                    r_wr_address <= r_wr_address + 1'b1;
                end
            end
        end
    end

    // read_again restarts from any state and wins over rd_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RD_IDLE;
            r_rd_address <= '0;
            r_rd_words   <= '0;
            r_rd_valid   <= 1'b0;
            r_read_done  <= 1'b0;
        end else begin
            r_read_done <= 1'b0;
            if (read_again) begin
                r_rd_words   <= w_words;
                r_rd_address <= '0;
                r_rd_valid   <= 1'b0;
                if (w_words == '0) begin
                    r_read_done <= 1'b1;
                    r_state     <= RD_IDLE;
                end else begin
                    r_state <= RD_ISSUE;
                end
            end else begin
                unique case (r_state)
                    RD_IDLE: begin
                        r_rd_valid <= 1'b0;
                    end
                    RD_ISSUE: begin
                        r_rd_valid <= 1'b1;
                        r_state    <= RD_HOLD;
                    end
                    RD_HOLD: begin
                        if (rd_ready) begin
                            r_rd_valid <= 1'b0;
                            if (r_rd_address == r_rd_words - 1'b1) begin
                                r_rd_address <= '0;
                                r_read_done  <= 1'b1;
                                r_state      <= RD_IDLE;
                            end else begin
                                r_rd_address <= r_rd_address + 1'b1;
                                r_state      <= RD_ISSUE;
                            end
                        end
                    end
                    default: begin
                        r_rd_valid <= 1'b0;
                        r_state    <= RD_IDLE;
                    end
                endcase
            end
        end
    end

    vector_ram #(
        .DEPTH (memory_height),
        .WIDTH (element_width * no_of_units),
        .IW    (IW)
    ) u_ram (
        .i_clk   (clk),
        .i_reset (reset),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_address[IW-1:0]),
        .i_wdata (wr_data),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_address[IW-1:0]),
        .o_rdata (rd_data)
    );

    assign rd_valid   = r_rd_valid;
    assign rd_address = r_rd_address;
    assign wr_address = r_wr_address;
    assign write_done = r_write_done;
    assign read_done  = r_read_done;

endmodule

// File: doc/cg_vector_stream_mem.md
Name: cg_vector_stream_mem

Overview:
- Memory-side endpoint for one CG vector (P, R or X) that absorbs the ALU's wide write-back stream and replays it to the ALU as a handshaked read stream.
- Sits between the ALU's result write strobes and its vector inputs, in the same position that memoryR_input/memoryR_output occupy in the ALU wrapper.
- Owns write and read address counters and supports restart (read_again).
- Flags the end of each pass on both the write and read sides.

Parameters:
- element_width, 32, bits per vector element
- no_of_units, 8, elements per memory word
- memory_height, 1000, words of storage
- address_width, $clog2(memory_height)+1, word address width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- total  in  32  vector length in elements
- wr_we  in  1  ALU write strobe; one word per asserted cycle
- wr_data  in  element_width*no_of_units  write word; element 0 in the LSBs
- read_again  in  1  single-cycle pulse; (re)start read pass at word 0
- rd_ready  in  1  ALU accepts the current rd_data
- rd_valid  out  1  rd_data holds a valid word
- rd_data  out  element_width*no_of_units  read word
- rd_address  out  address_width  word currently being read
- wr_address  out  address_width  next word to be written
- write_done  out  1  one-cycle pulse when the last word of a pass is written
- read_done  out  1  one-cycle pulse when the last word of a pass is accepted

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high. On reset:
  - rd_valid, rd_data, rd_address, wr_address, write_done and read_done go to 0.
  - The read FSM goes to IDLE.
  - Memory contents are not cleared.
- Word count: words = ceil(total/no_of_units), saturated at memory_height. Computed with 32-bit arithmetic as (total + no_of_units - 1) / no_of_units.
- Write side:
  - wr_words latches words on any wr_we cycle in which wr_address == 0.
  - On wr_we: mem[wr_address] <= wr_data.
  - If wr_address == wr_words-1: wr_address <= 0 and write_done = 1 for the next cycle. Otherwise wr_address increments.
  - If wr_words == 0: the write is dropped and write_done still pulses.
- Read FSM states: IDLE, ISSUE, HOLD.
  - IDLE: rd_valid = 0. On read_again, latch rd_words <= words and set rd_address <= 0. Go to ISSUE, or if rd_words == 0 pulse read_done and stay in IDLE.
  - ISSUE: a synchronous memory read of rd_address. Go to HOLD; data registers into rd_data on this edge.
  - HOLD: rd_valid = 1 and rd_data is stable until accepted.
    - On rd_ready with rd_address == rd_words-1: rd_address <= 0, read_done pulses next cycle, go to IDLE.
    - On rd_ready otherwise: rd_address increments, go to ISSUE.
    - Without rd_ready: hold.
- Latency and throughput: read_again to first rd_valid is 2 cycles. Peak throughput is 1 word per 2 cycles.
- Boundary conditions:
  - read_again in ISSUE/HOLD aborts the pass: rd_valid drops next cycle, rd_address = 0, FSM goes to ISSUE. read_done is not asserted for the aborted pass.
  - read_again takes priority over rd_ready in the same cycle.
  - Write and read of the same address in the same cycle: the read returns the old data (read-before-write).
  - Write and read counters are fully independent; a write pass may run concurrently with a read pass.
  - A change to total takes effect only at the next latch point (write address 0 / read_again).
  - Reset mid-pass: both counters go to 0, the FSM goes to IDLE, and no done pulses are issued.

Decomposition:
- Shared package cg_pkg holds:
  - the element_width / no_of_units / memory_height defaults
  - a clog2-based address-width constant
  - a words_of(total) function
- Sub-module vector_ram: memory_height x (element_width*no_of_units), one synchronous write port and one synchronous read port, read-before-write.
- Counters and the FSM stay in cg_vector_stream_mem.

Test Plan:
- Reset then total=20, wr_we for 3 consecutive cycles with words W0..W2 -> wr_address steps 0,1,2,0; write_done high exactly one cycle after the third write.
- total=20, read_again, rd_ready tied high -> rd_valid on cycle 2 with W0, then W1 and W2 every other cycle; read_done one cycle after W2 is accepted; FSM returns to IDLE.
- Read with rd_ready low for 5 cycles in HOLD -> rd_data and rd_address stable at W1/1 throughout; resumes correctly when rd_ready rises.
- read_again asserted while HOLD on word 1 -> rd_valid low next cycle; stream restarts with W0; no read_done for the aborted pass.
- wr_we to address 1 in the same cycle as the ISSUE of address 1 -> rd_data shows the old W1; the following pass shows the new value.
- total=0 -> read_again gives read_done next cycle with no rd_valid; wr_we gives write_done with memory unchanged. Reset asserted mid-read -> all outputs 0 next cycle.
